// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, and
// registered press / release / long-press event pulses.
module btn_debounce #(
    parameter int unsigned C_CLK_FREQ      = 100000000,
    parameter int unsigned C_DEBOUNCE_MS   = 20,
    parameter int unsigned C_LONG_PRESS_MS = 1000,
    parameter int unsigned C_ACTIVE_LOW    = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int unsigned C_DB_CYCLES   = C_CLK_FREQ / 1000 * C_DEBOUNCE_MS;
    localparam int unsigned C_LONG_CYCLES = C_CLK_FREQ / 1000 * C_LONG_PRESS_MS;
    localparam int unsigned DB_W          = $clog2(C_DB_CYCLES + 1);
    localparam int unsigned LONG_W        = $clog2(C_LONG_CYCLES + 1);
    localparam logic        C_REL_LVL     = (C_ACTIVE_LOW != 0);

    if (C_DB_CYCLES < 1) begin : g_bad_db
        $error("btn_debounce: debounce time rounds to zero clock cycles");
    end
    if (C_LONG_CYCLES < 1) begin : g_bad_long
        $error("btn_debounce: long-press time rounds to zero clock cycles");
    end

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_HELD         = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    state_t              state_q;
    logic                sync1_q;
    logic                sync2_q;
    logic [DB_W-1:0]     db_cnt_q;
    logic [LONG_W-1:0]   long_cnt_q;
    logic                level_q;
    logic                press_q;
    logic                release_q;
    logic                long_q;
    logic                s_btn;
    logic                long_run;

    // Synchronizer resets to the released pin level so reset exit is quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= C_REL_LVL;
            sync2_q <= C_REL_LVL;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    assign s_btn    = sync2_q ^ C_REL_LVL;
    assign long_run = ((state_q == S_HELD) || (state_q == S_RELEASE_WAIT)) &&
                      (long_cnt_q != LONG_W'(C_LONG_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            db_cnt_q   <= '0;
            long_cnt_q <= '0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;

            // Long counter keeps running through release glitches; saturates.
            if (long_run) begin
                long_cnt_q <= long_cnt_q + LONG_W'(1);
                if (long_cnt_q == LONG_W'(C_LONG_CYCLES - 1)) begin
                    long_q <= 1'b1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (s_btn) begin
                        state_q  <= S_PRESS_WAIT;
                        db_cnt_q <= '0;
                    end
                end
                S_PRESS_WAIT: begin
                    if (!s_btn) begin
                        state_q <= S_IDLE;
                    end else if (db_cnt_q == DB_W'(C_DB_CYCLES - 1)) begin
                        state_q    <= S_HELD;
                        level_q    <= 1'b1;
                        press_q    <= 1'b1;
                        long_cnt_q <= '0;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                    end
                end
                S_HELD: begin
                    if (!s_btn) begin
                        state_q  <= S_RELEASE_WAIT;
                        db_cnt_q <= '0;
                    end
                end
                S_RELEASE_WAIT: begin
                    if (s_btn) begin
                        state_q <= S_HELD;
                    end else if (db_cnt_q == DB_W'(C_DB_CYCLES - 1)) begin
                        state_q   <= S_IDLE;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_long    = long_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce: stimulus queues expected output events,
// a negedge monitor pops and compares whenever an output event appears.
module tb_btn_debounce;

    logic clk;
    logic rst;
    logic btn_in;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic btn_long;

    btn_debounce #(
        .C_CLK_FREQ      (1000),
        .C_DEBOUNCE_MS   (4),
        .C_LONG_PRESS_MS (10),
        .C_ACTIVE_LOW    (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );

    typedef struct {
        int   cyc;
        logic lvl;
        logic prs;
        logic rel;
        logic lng;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    logic prev_level = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic lvl, input logic prs,
                        input logic rel, input logic lng);
        exp_t e;
        e.cyc = c; e.lvl = lvl; e.prs = prs; e.rel = rel; e.lng = lng;
        q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_idle(input string name);
        vectors++;
        if ({btn_level, btn_press, btn_release, btn_long} != 4'b0000) begin
            miscompares++;
            $display("FAIL %s: got lvl/prs/rel/lng=%b required 0000 at cycle %0d",
                     name, {btn_level, btn_press, btn_release, btn_long}, cyc);
        end
    endtask

    // Monitor: any pulse or level change is an output event to be matched.
    always @(negedge clk) begin
        if (!rst && (btn_press || btn_release || btn_long || (btn_level != prev_level))) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event: got lvl/prs/rel/lng=%b at cycle %0d, required none",
                         {btn_level, btn_press, btn_release, btn_long}, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.cyc != cyc ||
                    {btn_level, btn_press, btn_release, btn_long} != {e.lvl, e.prs, e.rel, e.lng}) begin
                    miscompares++;
                    $display("FAIL event: got lvl/prs/rel/lng=%b at cycle %0d, required %b at cycle %0d",
                             {btn_level, btn_press, btn_release, btn_long}, cyc,
                             {e.lvl, e.prs, e.rel, e.lng}, e.cyc);
                end
            end
        end
        prev_level <= btn_level;
    end

    initial begin
        int t;
        int s;
        rst    = 1'b1;
        btn_in = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_idle("reset");
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_idle("post_reset");

        // Clean press: level/press at +7 from drive, long 10 after press.
        btn_in = 1'b0; t = cyc;
        push(t + 7, 1, 1, 0, 0);
        push(t + 17, 1, 0, 0, 1);
        wait_until(t + 20);
        btn_in = 1'b1;
        push(cyc + 7, 0, 0, 1, 0);
        repeat (12) @(negedge clk);

        // 3-cycle press glitch: no event at all.
        btn_in = 1'b0;
        repeat (3) @(negedge clk);
        btn_in = 1'b1;
        repeat (15) @(negedge clk);
        check_idle("press_glitch");

        // 2-cycle release glitch while held: long timing unchanged.
        btn_in = 1'b0; t = cyc;
        push(t + 7, 1, 1, 0, 0);
        push(t + 17, 1, 0, 0, 1);
        wait_until(t + 9);
        btn_in = 1'b1;
        wait_until(t + 11);
        btn_in = 1'b0;
        wait_until(t + 22);
        btn_in = 1'b1;
        push(cyc + 7, 0, 0, 1, 0);
        repeat (12) @(negedge clk);

        // Release sampled 3 cycles after press: release at press+9, no long.
        btn_in = 1'b0; t = cyc;
        push(t + 7, 1, 1, 0, 0);
        wait_until(t + 9);
        btn_in = 1'b1;
        push(t + 16, 0, 0, 1, 0);
        repeat (14) @(negedge clk);

        // Release acceptance coincides with long threshold.
        btn_in = 1'b0; t = cyc;
        push(t + 7, 1, 1, 0, 0);
        wait_until(t + 10);
        btn_in = 1'b1;
        push(t + 17, 0, 0, 1, 1);
        repeat (14) @(negedge clk);

        // Reset mid-press: silent drop, then re-accepted as a new press.
        btn_in = 1'b0; t = cyc;
        push(t + 7, 1, 1, 0, 0);
        wait_until(t + 12);
        rst = 1'b1;
        @(negedge clk);
        check_idle("reset_mid_press");
        @(negedge clk);
        check_idle("reset_mid_press_hold");
        rst = 1'b0; s = cyc;
        push(s + 7, 1, 1, 0, 0);
        push(s + 17, 1, 0, 0, 1);
        wait_until(s + 20);
        btn_in = 1'b1;
        push(cyc + 7, 0, 0, 1, 0);
        repeat (12) @(negedge clk);

        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_event: got nothing, required lvl/prs/rel/lng=%b at cycle %0d",
                     {e.lvl, e.prs, e.rel, e.lng}, e.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
